// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between cache line fill, CPU write and DMA read requesters.
// Optional DMA starvation guard: define ARB_STARVATION_GUARD_EN.
module sdram_port_arbiter #(
    parameter int unsigned BURSTLEN     = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_req,
    input  logic [31:0] cache_addr,
    output logic        cache_fill,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ack,
    input  logic        dma_req,
    input  logic [31:0] dma_addr,
    output logic        dma_fill,
    output logic        sdram_req,
    output logic        sdram_rw,
    output logic [31:0] sdram_addr,
    output logic [15:0] sdram_wdata,
    input  logic        sdram_ack,
    input  logic        sdram_fill,
    output logic [1:0]  grant,
    output logic        busy
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BEAT_W = $clog2(BURSTLEN + 1);

    localparam logic [1:0] GNT_NONE  = 2'd0;
    localparam logic [1:0] GNT_CACHE = 2'd1;
    localparam logic [1:0] GNT_WR    = 2'd2;
    localparam logic [1:0] GNT_DMA   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDREQ = 2'd1,
        BURST = 2'd2,
        WRREQ = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   beat_d;
    logic [BEAT_W-1:0]   beat_inc;
    logic                last_beat;
    logic [1:0]          grant_d;
    logic                req_d;
    logic                rw_d;
    logic                wr_ack_d;
    logic [ADDR_W-1:0]   addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                wr_pend;
    logic                rotate;
    logic [1:0]          winner;
    logic                in_read;

    // The retiring write still holds wr_req during its wr_ack cycle; do not grant it twice.
    assign wr_pend = wr_req & ~wr_ack;

`ifdef ARB_STARVATION_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 2);

    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;

    assign rotate = (starve_q >= STARVE_W'(STARVE_LIMIT));

    // Consecutive DMA grants that overtook a waiting write or cache request.
    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE) begin
            if (winner == GNT_DMA) begin
                if ((wr_pend | cache_req) && !rotate) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end else if (winner != GNT_NONE) begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign rotate = 1'b0;
`endif

    // Fixed priority DMA > write > cache, inverted to write > cache > DMA when rotating.
    always_comb begin
        winner = GNT_NONE;
        if (rotate) begin
            if (wr_pend) begin
                winner = GNT_WR;
            end else if (cache_req) begin
                winner = GNT_CACHE;
            end else if (dma_req) begin
                winner = GNT_DMA;
            end
        end else begin
            if (dma_req) begin
                winner = GNT_DMA;
            end else if (wr_pend) begin
                winner = GNT_WR;
            end else if (cache_req) begin
                winner = GNT_CACHE;
            end
        end
    end

    assign beat_inc  = beat_q + BEAT_W'(1);
    assign last_beat = (beat_inc == BEAT_W'(BURSTLEN));

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        grant_d  = grant;
        req_d    = sdram_req;
        rw_d     = sdram_rw;
        addr_d   = sdram_addr;
        wdata_d  = sdram_wdata;
        wr_ack_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                grant_d = GNT_NONE;
                if (winner != GNT_NONE) begin
                    grant_d = winner;
                    req_d   = 1'b1;
                    beat_d  = '0;
                    unique case (winner)
                        GNT_WR: begin
                            addr_d  = wr_addr;
                            wdata_d = wr_data;
                            rw_d    = 1'b0;
                            state_d = WRREQ;
                        end
                        GNT_DMA: begin
                            addr_d  = dma_addr;
                            rw_d    = 1'b1;
                            state_d = RDREQ;
                        end
                        default: begin
                            addr_d  = cache_addr;
                            rw_d    = 1'b1;
                            state_d = RDREQ;
                        end
                    endcase
                end
            end
            RDREQ, BURST: begin
                // A fill seen while still requesting doubles as the ack and the first beat.
                if (sdram_fill) begin
                    req_d  = 1'b0;
                    beat_d = beat_inc;
                    if (last_beat) begin
                        state_d = IDLE;
                        grant_d = GNT_NONE;
                    end else begin
                        state_d = BURST;
                    end
                end else if ((state_q == RDREQ) && sdram_ack) begin
                    req_d   = 1'b0;
                    state_d = BURST;
                end
            end
            WRREQ: begin
                if (sdram_ack) begin
                    req_d    = 1'b0;
                    wr_ack_d = 1'b1;
                    grant_d  = GNT_NONE;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            grant       <= GNT_NONE;
            sdram_req   <= 1'b0;
            sdram_rw    <= 1'b0;
            sdram_addr  <= '0;
            sdram_wdata <= '0;
            wr_ack      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            grant       <= grant_d;
            sdram_req   <= req_d;
            sdram_rw    <= rw_d;
            sdram_addr  <= addr_d;
            sdram_wdata <= wdata_d;
            wr_ack      <= wr_ack_d;
            busy        <= (state_d != IDLE);
        end
    end

    // Zero-latency fill routing; reset in the same cycle suppresses the beat.
    assign in_read    = (state_q == RDREQ) || (state_q == BURST);
    assign cache_fill = sdram_fill & ~reset & in_read & (grant == GNT_CACHE);
    assign dma_fill   = sdram_fill & ~reset & in_read & (grant == GNT_DMA);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: random controller timing, batched requests,
// starvation scenario and reset mid-burst.
module tb_sdram_port_arbiter;
    localparam int unsigned BL = 8;
    localparam int unsigned SL = 4;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [31:0] addr;
        logic        rw;
        logic [15:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cache_req = 1'b0;
    logic [31:0] cache_addr = '0;
    logic        cache_fill;
    logic        wr_req = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ack;
    logic        dma_req = 1'b0;
    logic [31:0] dma_addr = '0;
    logic        dma_fill;
    logic        sdram_req;
    logic        sdram_rw;
    logic [31:0] sdram_addr;
    logic [15:0] sdram_wdata;
    logic        sdram_ack = 1'b0;
    logic        sdram_fill = 1'b0;
    logic [1:0]  grant;
    logic        busy;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.BURSTLEN(BL), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .cache_req(cache_req), .cache_addr(cache_addr), .cache_fill(cache_fill),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_fill(dma_fill),
        .sdram_req(sdram_req), .sdram_rw(sdram_rw), .sdram_addr(sdram_addr),
        .sdram_wdata(sdram_wdata), .sdram_ack(sdram_ack), .sdram_fill(sdram_fill),
        .grant(grant), .busy(busy)
    );

    txn_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_active = 1'b0;
    txn_t cur;
    int   beats = 0;
    bit   ctrl_en = 1'b1;
    bit   ctrl_busy = 1'b0;
    int   dma_seen = 0;
    int   dma_drop_at = 2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a batch of requests together; the expected service order is pure priority.
    task automatic issue(input bit c, input bit w, input bit d, input logic [31:0] ca,
                         input logic [31:0] wa, input logic [15:0] wd, input logic [31:0] da);
        tick();
        if (d) exp_q.push_back('{gnt: 2'd3, addr: da, rw: 1'b1, wdata: 16'h0});
        if (w) exp_q.push_back('{gnt: 2'd2, addr: wa, rw: 1'b0, wdata: wd});
        if (c) exp_q.push_back('{gnt: 2'd1, addr: ca, rw: 1'b1, wdata: 16'h0});
        if (d) begin dma_seen = 0; dma_addr = da; dma_req = 1'b1; end
        if (w) begin wr_addr = wa; wr_data = wd; wr_req = 1'b1; end
        if (c) begin cache_addr = ca; cache_req = 1'b1; end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!(exp_q.size() == 0 && !mon_active && !busy && !cache_req && !wr_req &&
                     !dma_req && !ctrl_busy) && n < 3000);
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL timeout_%s: still busy after %0d cycles, %0d txns pending", name, n, exp_q.size());
        end
    endtask

    // Controller model: random ack latency, optional fill-as-ack, random gaps between beats.
    initial begin : controller
        int d;
        int g;
        bit rw;
        bit fa;
        bit both;
        forever begin
            @(negedge clk);
            if (ctrl_en && sdram_req && !reset) begin
                ctrl_busy = 1'b1;
                rw   = sdram_rw;
                d    = $urandom_range(0, 3);
                fa   = rw && ($urandom_range(0, 3) == 0);
                both = fa && ($urandom_range(0, 1) == 1);
                tick();
                repeat (d) tick();
                if (!fa) begin
                    sdram_ack = 1'b1;
                    tick();
                    sdram_ack = 1'b0;
                end
                if (rw) begin
                    for (int b = 0; b < int'(BL); b++) begin
                        g = (b == 0 && fa) ? 0 : $urandom_range(0, 2);
                        repeat (g) tick();
                        sdram_fill = 1'b1;
                        sdram_ack  = (b == 0) && both;
                        tick();
                        sdram_fill = 1'b0;
                        sdram_ack  = 1'b0;
                    end
                end
                ctrl_busy = 1'b0;
            end
        end
    end

    // Requesters release per protocol: cache on first fill, DMA on fill dma_drop_at, write on wr_ack.
    initial begin : requesters
        bit cf;
        bit df;
        bit wa;
        bit dd;
        forever begin
            @(negedge clk);
            cf = cache_fill;
            df = dma_fill;
            wa = wr_ack;
            if (df) dma_seen++;
            dd = df && (dma_seen == dma_drop_at);
            if (cf || dd || wa) begin
                tick();
                if (cf) cache_req = 1'b0;
                if (dd) dma_req = 1'b0;
                if (wa) wr_req = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit after_reset;
        bit req_next;
        bit rd_done;
        bit wr_done;
        bit req_drop;
        bit prev_req;
        bit exp_cf;
        bit exp_df;
        after_reset = 0; req_next = 0; rd_done = 0; wr_done = 0; req_drop = 0; prev_req = 0;
        forever begin
            @(negedge clk);
            if (after_reset)
                check("reset_values", 64'({grant, sdram_req, sdram_rw, sdram_addr, sdram_wdata,
                                          wr_ack, busy, cache_fill, dma_fill}), 64'(0));
            if (req_next) check("req_at_n_plus_1", 64'({sdram_req, busy}), 64'(2'b11));
            if (rd_done) begin
                check("burst_end_idle", 64'({grant, sdram_req, busy}), 64'(0));
                mon_active = 1'b0;
            end
            if (wr_done) begin
                check("wr_ack_pulse", 64'({wr_ack, sdram_req, grant}), 64'(4'b1000));
                mon_active = 1'b0;
            end else if (wr_ack) begin
                check("wr_ack_spurious", 64'(wr_ack), 64'(0));
            end
            if (req_drop) check("req_drop_after_ack", 64'(sdram_req), 64'(0));
            after_reset = 0; req_next = 0; rd_done = 0; wr_done = 0; req_drop = 0;

            if (reset) begin
                check("fill_during_reset", 64'({cache_fill, dma_fill}), 64'(0));
                mon_active  = 1'b0;
                after_reset = 1'b1;
                prev_req    = 1'b0;
                continue;
            end

            if (sdram_req && !prev_req) begin
                check("no_overlap", 64'(mon_active), 64'(0));
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_grant: got grant %0d addr %h, expected no transaction", grant, sdram_addr);
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_txn", 64'({grant, sdram_addr, sdram_rw, busy}),
                          64'({cur.gnt, cur.addr, cur.rw, 1'b1}));
                    if (!cur.rw) check("write_data", 64'(sdram_wdata), 64'(cur.wdata));
                    mon_active = 1'b1;
                    beats = 0;
                end
            end

            exp_cf = sdram_fill && mon_active && cur.rw && (cur.gnt == 2'd1) && (beats < int'(BL));
            exp_df = sdram_fill && mon_active && cur.rw && (cur.gnt == 2'd3) && (beats < int'(BL));
            if (sdram_fill || cache_fill || dma_fill)
                check("fill_route", 64'({cache_fill, dma_fill}), 64'({exp_cf, exp_df}));
            if (sdram_fill && mon_active && cur.rw && beats < int'(BL)) begin
                if (sdram_req) req_drop = 1'b1;
                beats++;
                if (beats == int'(BL)) rd_done = 1'b1;
            end
            if (sdram_ack && sdram_req && mon_active) begin
                if (cur.rw) req_drop = 1'b1;
                else wr_done = 1'b1;
            end
            req_next = !busy && (dma_req || cache_req || (wr_req && !wr_ack));
            prev_req = sdram_req;
        end
    end

    initial begin : stimulus
        int n;
        logic [2:0] m;
        repeat (3) tick();
        reset = 1'b0;

        issue(1'b1, 1'b0, 1'b0, 32'h00001230, 32'h0, 16'h0, 32'h0);
        wait_idle("single_cache");
        issue(1'b0, 1'b1, 1'b0, 32'h0, 32'h40000010, 16'hBEEF, 32'h0);
        wait_idle("single_write");
        issue(1'b1, 1'b1, 1'b1, $urandom, $urandom, 16'($urandom_range(0, 65535)), $urandom);
        wait_idle("all_three");

        for (int i = 0; i < 20; i++) begin
            m = 3'($urandom_range(1, 7));
            issue(m[0], m[1], m[2], $urandom, $urandom, 16'($urandom_range(0, 65535)), $urandom);
            wait_idle("random_batch");
        end

        // DMA held through six bursts with a cache request waiting behind it.
        tick();
        dma_seen    = 0;
        dma_drop_at = 5 * int'(BL) + 1;
        dma_addr    = 32'hD0000100;
        cache_addr  = 32'h00002240;
`ifdef ARB_STARVATION_GUARD_EN
        for (int i = 0; i < 4; i++) exp_q.push_back('{gnt: 2'd3, addr: dma_addr, rw: 1'b1, wdata: 16'h0});
        exp_q.push_back('{gnt: 2'd1, addr: cache_addr, rw: 1'b1, wdata: 16'h0});
        for (int i = 0; i < 2; i++) exp_q.push_back('{gnt: 2'd3, addr: dma_addr, rw: 1'b1, wdata: 16'h0});
`else
        for (int i = 0; i < 6; i++) exp_q.push_back('{gnt: 2'd3, addr: dma_addr, rw: 1'b1, wdata: 16'h0});
        exp_q.push_back('{gnt: 2'd1, addr: cache_addr, rw: 1'b1, wdata: 16'h0});
`endif
        dma_req   = 1'b1;
        cache_req = 1'b1;
        wait_idle("dma_held");
        dma_drop_at = 2;

        // Reset lands on beat 4 of a DMA burst; stray beats afterwards must not be routed.
        ctrl_en = 1'b0;
        issue(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 16'h0, 32'hA5A5_0040);
        n = 0;
        while (!sdram_req && n < 50) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL timeout_reset_grant: sdram_req %b after %0d cycles, expected 1", sdram_req, n);
        end
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        for (int b = 0; b < 3; b++) begin
            sdram_fill = 1'b1;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        sdram_fill = 1'b0;
        ctrl_en = 1'b1;
        wait_idle("after_reset");

        issue(1'b1, 1'b1, 1'b0, $urandom, $urandom, 16'($urandom_range(0, 65535)), 32'h0);
        wait_idle("post_reset_batch");

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Shares the single 16-bit SDRAM controller port between three requesters: the direct-mapped cache line-fill path, the CPU write path, and a video/DMA read path. It sits between the cache/CPU/DMA blocks and the SDRAM controller. It latches the winning request's address and data, and holds the controller handshake. It routes the `sdram_fill` strobe of each read burst to the requester that owns it. Read data is broadcast externally; this block does not carry it.

## Interface
- `BURSTLEN`, default 8: halfword beats per read burst, i.e. `sdram_fill` cycles (8 = four 32-bit words).
- `STARVE_LIMIT`, default 4: consecutive DMA grants tolerated while another request waits. Used only when the guard is compiled in.
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `cache_req` in 1: cache wants a line fill, held until its first `cache_fill`.
- `cache_addr` in 32: line address, sampled at grant.
- `cache_fill` out 1: `sdram_fill` qualified for the cache burst.
- `wr_req` in 1: CPU write request, held until `wr_ack`.
- `wr_addr` in 32: write address, sampled at grant.
- `wr_data` in 16: write data, sampled at grant.
- `wr_ack` out 1: one-cycle completion pulse.
- `dma_req` in 1: DMA wants a read burst, held until its first `dma_fill`.
- `dma_addr` in 32: burst address, sampled at grant.
- `dma_fill` out 1: `sdram_fill` qualified for the DMA burst.
- `sdram_req` out 1: request to the controller.
- `sdram_rw` out 1: 1 = read burst, 0 = single write.
- `sdram_addr` out 32: latched address.
- `sdram_wdata` out 16: latched write data.
- `sdram_ack` in 1: controller accepted the request; for writes this also means the write is complete.
- `sdram_fill` in 1: read data beat valid.
- `grant` out 2: owner of the port: 0 none, 1 cache, 2 write, 3 DMA.
- `busy` out 1: high in any state other than IDLE.

## Operation
- The state machine has four states: IDLE, RDREQ, BURST, WRREQ.
- **IDLE:**
  - Arbitrate among the asserted requests. Fixed priority is DMA > write > cache.
  - On a winner, latch the address (and `wr_data` for a write), set `grant`, assert `sdram_req` and set `sdram_rw`.
  - Go to RDREQ for cache/DMA, or to WRREQ for a write.
- **RDREQ:**
  - Hold `sdram_req` until `sdram_ack`, then deassert it and go to BURST.
  - If `sdram_fill` arrives before or together with `sdram_ack`, treat it as both the ack and beat 1, and count it.
- **BURST:**
  - Forward each `sdram_fill` to the owner's fill output. Count beats.
  - After beat `BURSTLEN`, go to IDLE with `grant` = 0.
  - The owner dropping its request mid-burst does not abort the burst; the remaining beats are still counted and forwarded.
- **WRREQ:**
  - Hold `sdram_req` until `sdram_ack`.
  - Then deassert it, pulse `wr_ack`, and go to IDLE.
- Beat counter: `$clog2(BURSTLEN+1)` bits, cleared on grant. `sdram_fill` is ignored in IDLE and WRREQ.
- A request that is not granted in IDLE stays pending. It is re-evaluated on every IDLE cycle.
- Reset mid-operation returns the block to IDLE with all outputs at their reset values. No partial beat is forwarded afterwards.

## Timing
- **Reset values:**
  - `sdram_req`, `sdram_rw`, `cache_fill`, `dma_fill`, `wr_ack` and `busy` are 0.
  - `grant` is 0.
  - `sdram_addr` and `sdram_wdata` are 0.
- Request sampled in IDLE at cycle N: `sdram_req`, `grant` and `busy` are high at N+1.
- `sdram_ack` at cycle M: `sdram_req` is low at M+1.
- `wr_ack` is high for exactly cycle M+1 (write path).
- `cache_fill`/`dma_fill` are combinational: `sdram_fill & (state==BURST or RDREQ) & grant match`. This gives zero added latency, as the cache requires.
- The last beat at cycle K returns the block to IDLE at K+1. A new arbitration grant appears at K+2.
- Minimum turnaround between back-to-back bursts is 2 cycles.
- Simultaneous `reset` and `sdram_fill`: reset wins and no fill is forwarded.

## Configuration
- `ARB_STARVATION_GUARD_EN`, when defined:
  - A counter tracks consecutive DMA grants made while `wr_req` or `cache_req` was pending.
  - When the counter reaches `STARVE_LIMIT`, the next IDLE arbitration uses write > cache > DMA.
  - The counter clears on any non-DMA grant and on reset.
- When undefined: strict DMA > write > cache priority, and no counter is built.

## Test plan
- **Single cache fill:**
  - Stimulus: `cache_req` with `cache_addr`=0x00001230; the controller acks at cycle 3, then gives 8 fills.
  - Response: `sdram_addr`=0x00001230, `sdram_rw`=1 and `grant`=1. Exactly 8 `cache_fill` pulses; `grant`=0 one cycle after the 8th.
- **Write:**
  - Stimulus: `wr_req` with `wr_addr`=0x40000010 and `wr_data`=0xBEEF; ack 2 cycles after `sdram_req`.
  - Response: `sdram_rw`=0 and `sdram_wdata`=0xBEEF. A single `wr_ack` pulse the cycle after `sdram_ack`; no fill outputs toggle.
- **Simultaneous requests:**
  - Stimulus: cache, write and DMA requests all asserted in the same cycle.
  - Response: grant order is DMA (3), then write (2), then cache (1). Each completes before the next `sdram_req`.
- **Abandoned burst:**
  - Stimulus: DMA drops `dma_req` after fill beat 2.
  - Response: beats 3–8 are still counted and pulse `dma_fill`; the state returns to IDLE only after beat 8.
- **Reset mid-burst:**
  - Stimulus: `reset` asserted during beat 4.
  - Response: the next cycle shows `grant`=0, `busy`=0 and `sdram_req`=0, and no fill pulses follow.
- **Guard enabled:**
  - Stimulus: `ARB_STARVATION_GUARD_EN` defined, `STARVE_LIMIT`=4, `dma_req` held high and `cache_req` pending.
  - Response: 4 DMA bursts, then 1 cache burst, then DMA resumes. With the guard undefined, the cache is never granted while DMA stays high.
